// File: rtl/modular_adder_pipe.sv
// Two-stage pipelined modular adder c = (a + b) mod q, with optional multiply by 2^-1 mod q.
// Valid/ready handshake on both sides; each stage loads whenever it is empty or drains downstream.
module modular_adder_pipe #(
  parameter int MOD_INDEX = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [29:0] a,
  input  logic [29:0] b,
  input  logic        halve,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [29:0] c
);

  localparam int DATA_W = 30;

  function automatic logic [DATA_W-1:0] sel_mod(input int idx);
    case (idx)
      0:       sel_mod = 30'd1063321601;
      1:       sel_mod = 30'd1063452673;
      2:       sel_mod = 30'd1064697857;
      3:       sel_mod = 30'd1065484289;
      4:       sel_mod = 30'd1065811969;
      5:       sel_mod = 30'd1068236801;
      6:       sel_mod = 30'd1068433409;
      7:       sel_mod = 30'd1068564481;
      8:       sel_mod = 30'd1069219841;
      9:       sel_mod = 30'd1070727169;
      10:      sel_mod = 30'd1071513601;
      11:      sel_mod = 30'd1072496641;
      default: sel_mod = 30'd1073479681;
    endcase
  endfunction

  localparam logic [DATA_W-1:0] Q = sel_mod(MOD_INDEX);

  // Conditional subtract, then halving: q is odd, so r + q is even whenever r is odd.
  function automatic logic [DATA_W-1:0] reduce_halve(input logic [DATA_W:0] s, input logic h);
    logic [DATA_W:0]   r;
    logic [DATA_W+1:0] t;
    r = (s >= {1'b0, Q}) ? s - {1'b0, Q} : s;
    if (h && r[0])
      t = ({1'b0, r} + {2'b00, Q}) >> 1;
    else if (h)
      t = {1'b0, r} >> 1;
    else
      t = {1'b0, r};
    return DATA_W'(t);
  endfunction

  logic              vld_p1_q, vld_p1_d;
  logic              vld_p2_q, vld_p2_d;
  logic [DATA_W:0]   sum_p1_q;
  logic              halve_p1_q;
  logic [DATA_W-1:0] c_p2_q, c_p2_d;
  logic              adv_p1, adv_p2, in_xfer;

  always_comb begin
    adv_p2   = !vld_p2_q || out_ready;
    adv_p1   = !vld_p1_q || adv_p2;
    in_ready = adv_p1 && !rst;
    in_xfer  = in_valid && in_ready;
    vld_p1_d = adv_p1 ? in_xfer : vld_p1_q;
    vld_p2_d = adv_p2 ? vld_p1_q : vld_p2_q;
    c_p2_d   = (adv_p2 && vld_p1_q) ? reduce_halve(sum_p1_q, halve_p1_q) : c_p2_q;
  end

  // Stage 1: operand sum and halve flag, captured only on an input transfer
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      sum_p1_q   <= {1'b0, a} + {1'b0, b};
      halve_p1_q <= halve;
    end
  end

  // Stage 2: reduced result; reset clears the output word as well as the valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      c_p2_q   <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      c_p2_q   <= c_p2_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign c         = c_p2_q;

endmodule

// File: tb/tb_modular_adder_pipe.sv
// Bench for modular_adder_pipe: directed boundary cases, backpressure, reset flush,
// and a long randomized stream scored against an arithmetic reference model.
module tb_modular_adder_pipe;

  localparam longint Q0  = 64'd1063321601;
  localparam longint Q5  = 64'd1068236801;
  localparam longint Q12 = 64'd1073479681;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [29:0] a, b;
  logic        halve;
  logic        out_ready;
  logic        in_ready, out_valid;
  logic [29:0] c;
  logic        in_ready5, out_valid5, in_ready12, out_valid12;
  logic [29:0] c5, c12;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  modular_adder_pipe #(.MOD_INDEX(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .halve(halve), .out_valid(out_valid), .out_ready(out_ready), .c(c));
  modular_adder_pipe #(.MOD_INDEX(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready5), .a(a), .b(b),
    .halve(halve), .out_valid(out_valid5), .out_ready(out_ready), .c(c5));
  modular_adder_pipe #(.MOD_INDEX(12)) dut12 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready12), .a(a), .b(b),
    .halve(halve), .out_valid(out_valid12), .out_ready(out_ready), .c(c12));

  // Reference: (a+b) mod q, or (a+b) times the modular inverse of 2, mod q.
  function automatic longint ref_mod(input longint q, input longint x, input longint y,
                                     input logic h);
    longint s;
    s = x + y;
    if (h) return (s * ((q + 1) / 2)) % q;
    return s % q;
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_check(input string tag, input longint x, input longint y, input logic h,
                            input longint exp);
    in_valid = 1'b1; a = 30'(x); b = 30'(y); halve = h;
    #1 check({tag, "_in_ready"}, longint'(in_ready), 1);
    step();
    in_valid = 1'b0;
    #1 check({tag, "_lat1_out_valid"}, longint'(out_valid), 0);
    step();
    #1 check({tag, "_out_valid"}, longint'(out_valid), 1);
    check({tag, "_c"}, longint'(c), exp);
  endtask

  logic [29:0] ra, rb;
  logic        rh;
  longint      exp_q[$];
  longint      expv;
  int          sent, recv, cyc;
  logic        prev_stall;
  logic [29:0] prev_c;
  logic        xin, xout;

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; halve = 1'b0; out_ready = 1'b1;
    step(); step();
    #1 check("rst_out_valid", longint'(out_valid), 0);
    check("rst_c", longint'(c), 0);
    check("rst_in_ready", longint'(in_ready), 0);
    rst = 1'b0;
    #1 check("post_rst_in_ready", longint'(in_ready), 1);

    send_check("add_wrap_to_0", Q0 - 1, 1, 1'b0, 0);
    send_check("add_small", 5, 3, 1'b0, 8);
    send_check("add_2q_minus_2", Q0 - 1, Q0 - 1, 1'b0, Q0 - 2);
    send_check("halve_odd", 2, 1, 1'b1, 531660802);
    send_check("halve_even", 4, 2, 1'b1, 3);
    send_check("halve_q", Q0 - 1, 1, 1'b1, 0);

    // Other moduli: the MOD_INDEX=0 instance sees out-of-contract operands here and is ignored.
    in_valid = 1'b1; a = 30'(Q12 - 1); b = 30'd2; halve = 1'b0;
    step(); in_valid = 1'b0; step();
    #1 check("m12_out_valid", longint'(out_valid12), 1);
    check("m12_c", longint'(c12), 1);
    in_valid = 1'b1; a = 30'(Q5 - 1); b = 30'(Q5 - 1); halve = 1'b0;
    step(); in_valid = 1'b0; step();
    #1 check("m5_out_valid", longint'(out_valid5), 1);
    check("m5_c", longint'(c5), Q5 - 2);
    check("m5_in_ready", longint'(in_ready5), 1);
    step();

    // Backpressure: two beats fill the pipe, in_ready drops, release drains 2,4,6,8.
    out_ready = 1'b0;
    in_valid = 1'b1; a = 30'd1; b = 30'd1;
    #1 check("bp_in_ready_b1", longint'(in_ready), 1);
    step();
    a = 30'd2; b = 30'd2;
    #1 check("bp_in_ready_b2", longint'(in_ready), 1);
    step();
    a = 30'd3; b = 30'd3;
    #1 check("bp_full_in_ready", longint'(in_ready), 0);
    check("bp_head_c", longint'(c), 2);
    step();
    #1 check("bp_hold_in_ready", longint'(in_ready), 0);
    check("bp_hold_valid", longint'(out_valid), 1);
    check("bp_hold_c", longint'(c), 2);
    step(); step();
    out_ready = 1'b1;
    #1 check("bp_rel_in_ready", longint'(in_ready), 1);
    check("bp_out1", longint'(c), 2);
    step();
    a = 30'd4; b = 30'd4;
    #1 check("bp_out2", longint'(c), 4);
    step();
    in_valid = 1'b0;
    #1 check("bp_out3", longint'(c), 6);
    step();
    #1 check("bp_out4", longint'(c), 8);
    check("bp_out4_valid", longint'(out_valid), 1);
    step();
    #1 check("bp_drained", longint'(out_valid), 0);

    // Reset with two beats in flight.
    in_valid = 1'b1; a = 30'd10; b = 30'd10;
    step();
    a = 30'd20; b = 30'd20;
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    #1 check("mid_rst_out_valid", longint'(out_valid), 0);
    check("mid_rst_c", longint'(c), 0);
    check("mid_rst_in_ready", longint'(in_ready), 0);
    rst = 1'b0;
    #1 check("mid_rst_release_in_ready", longint'(in_ready), 1);
    step();
    #1 check("no_stale_1", longint'(out_valid), 0);
    step();
    #1 check("no_stale_2", longint'(out_valid), 0);

    // Random stream scored against the reference model.
    sent = 0; recv = 0; cyc = 0; prev_stall = 1'b0; prev_c = '0;
    while (recv < 10000 && cyc < 60000) begin
      if (sent < 10000 && $urandom_range(3, 0) != 0) begin
        case ($urandom_range(7, 0))
          0: begin ra = 30'(Q0 - 1); rb = 30'(Q0 - 1); end
          1: begin ra = '0; rb = '0; end
          2: begin ra = 30'(Q0 - 1); rb = 30'd1; end
          default: begin ra = 30'($urandom_range(32'(Q0 - 1), 0)); rb = 30'($urandom_range(32'(Q0 - 1), 0)); end
        endcase
        rh = 1'($urandom_range(1, 0));
        in_valid = 1'b1; a = ra; b = rb; halve = rh;
      end else begin
        in_valid = 1'b0;
        a = 30'($urandom); b = 30'($urandom); halve = 1'($urandom);
      end
      out_ready = ($urandom_range(3, 0) != 0);
      #1;
      if (prev_stall) begin
        check("rnd_stall_valid", longint'(out_valid), 1);
        check("rnd_stall_c", longint'(c), longint'(prev_c));
      end
      xin  = in_valid && in_ready;
      xout = out_valid && out_ready;
      if (xin) begin
        exp_q.push_back(ref_mod(Q0, longint'(a), longint'(b), halve));
        sent++;
      end
      if (xout) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_beat", 1, 0);
        end else begin
          expv = exp_q.pop_front();
          check("rnd_c", longint'(c), expv);
          tests++;
          assert (longint'(c) < Q0) else begin
            fails++;
            $error("FAIL rnd_c_range: observed %0d required below %0d", c, Q0);
          end
        end
        recv++;
      end
      prev_stall = out_valid && !out_ready;
      prev_c = c;
      step();
      cyc++;
    end
    check("rnd_all_beats_received", longint'(recv), 10000);
    check("rnd_queue_empty", longint'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
